// File: rtl/rns64_pkg.sv
// rtl/rns64_pkg.sv - shared RNS(2^21-1, 2^21, 2^22+1) word layout, moduli and types
package rns64_pkg;

  localparam int RNS_W  = 65;

  localparam int R0_W   = 21;
  localparam int R1_W   = 21;
  localparam int R2_W   = 23;

  localparam int R0_LSB = 0;
  localparam int R1_LSB = 21;
  localparam int R2_LSB = 42;

  localparam int unsigned M0 = (1 << 21) - 1;
  localparam int unsigned M1 = (1 << 21);
  localparam int unsigned M2 = (1 << 22) + 1;

  // Residue word: r0 occupies the low bits, r2 the high bits.
  typedef struct packed {
    logic [R2_W-1:0] r2;
    logic [R1_W-1:0] r1;
    logic [R0_W-1:0] r0;
  } rns64_t;

  // Shape of a channel modulus, selects the reduction circuit.
  typedef enum int {
    MK_MINUS1,
    MK_POW2,
    MK_PLUS1
  } mod_kind_e;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/rns_mac_64_if.sv
// rtl/rns_mac_64_if.sv - operand-in / result-out handshake bundle of the RNS MAC stage
interface rns_mac_64_if #(
  parameter int CNT_W = 16
) ();
  import rns64_pkg::*;

  logic             in_valid;
  logic             in_ready;
  rns64_t           in_a;
  rns64_t           in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  rns64_t           out_data;
  logic [CNT_W-1:0] out_terms;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_terms
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_terms
  );

endinterface

// File: rtl/rns_mod_reduce.sv
// rtl/rns_mod_reduce.sv - reduce a raw channel product mod M and add it to the accumulator
module rns_mod_reduce import rns64_pkg::*; #(
  parameter mod_kind_e KIND = MK_MINUS1,
  parameter int        N    = 21,
  parameter int        W    = 21,
  parameter int        PW   = 42
) (
  input  logic [PW-1:0] i_prod,
  input  logic [W-1:0]  i_acc,
  output logic [W-1:0]  o_sum
);

  localparam int unsigned M_INT = (KIND == MK_MINUS1) ? ((1 << N) - 1) :
                                  (KIND == MK_POW2)   ?  (1 << N)      :
                                                         ((1 << N) + 1);
  localparam logic [W:0]  M_EXT = (W+1)'(M_INT);

  logic [W-1:0] w_red;
  logic [W:0]   w_add;

  generate
    if (KIND == MK_MINUS1) begin : g_minus1
      // 2^N == 1: fold high half onto low half twice; the all-ones pattern is zero.
      logic [N:0]   w_s1;
      logic [N-1:0] w_s2;
      assign w_s1  = {1'b0, i_prod[2*N-1:N]} + {1'b0, i_prod[N-1:0]};
      assign w_s2  = w_s1[N-1:0] + {{(N-1){1'b0}}, w_s1[N]};
      assign w_red = (w_s2 == M_EXT[N-1:0]) ? '0 : W'(w_s2);
    end else if (KIND == MK_POW2) begin : g_pow2
      logic w_unused_hi;
      assign w_red       = i_prod[W-1:0];
      assign w_unused_hi = ^i_prod[PW-1:W];
    end else begin : g_plus1
      // 2^N == -1: low part minus high part, corrected by one M when negative.
      localparam int TW = PW - N + 1;
      logic [TW-1:0] w_t;
      logic [TW-1:0] w_tc;
      logic          w_unused_hi;
      assign w_t         = {{(TW-N){1'b0}}, i_prod[N-1:0]} - {1'b0, i_prod[PW-1:N]};
      assign w_tc        = w_t[TW-1] ? (w_t + TW'(M_INT)) : w_t;
      assign w_red       = w_tc[W-1:0];
      assign w_unused_hi = ^w_tc[TW-1:W];
    end
  endgenerate

  assign w_add = {1'b0, i_acc} + {1'b0, w_red};
  assign o_sum = (w_add >= M_EXT) ? W'(w_add - M_EXT) : w_add[W-1:0];

endmodule

// File: rtl/rns_mac_64.sv
// rtl/rns_mac_64.sv - streaming per-channel RNS sum-of-products, one result per burst
module rns_mac_64 import rns64_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  rns_mac_64_if.slave  bus
);

  state_e           r_state;
  state_e           w_next;
  logic             w_accept;
  logic             w_s2_done;
  logic [41:0]      r_p0;
  logic [41:0]      r_p1;
  logic [45:0]      r_p2;
  logic             r_s1_valid;
  logic             r_s1_last;
  rns64_t           r_acc;
  rns64_t           w_sum;
  logic [CNT_W-1:0] r_cnt;
  rns64_t           r_out_data;
  logic [CNT_W-1:0] r_out_terms;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_s2_done = r_s1_valid && r_s1_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_next;
  end

  // Next state: drain the pipeline after the last pair, hold until the result is taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && bus.in_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_s2_done)               w_next = ST_HOLD;
      ST_HOLD:  if (bus.out_ready)           w_next = ST_ACCUM;
      default:                               w_next = ST_ACCUM;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (r_state == ST_ACCUM);
    bus.out_valid = (r_state == ST_HOLD);
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_terms = r_out_terms;

  // Stage 1: raw per-channel products of the accepted pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && bus.in_last;
      if (w_accept) begin
        r_p0 <= 42'(bus.in_a.r0) * 42'(bus.in_b.r0);
        r_p1 <= 42'(bus.in_a.r1) * 42'(bus.in_b.r1);
        r_p2 <= 46'(bus.in_a.r2) * 46'(bus.in_b.r2);
      end
    end
  end

  rns_mod_reduce #(.KIND(MK_MINUS1), .N(21), .W(R0_W), .PW(42)) u_red0 (
    .i_prod (r_p0),
    .i_acc  (r_acc.r0),
    .o_sum  (w_sum.r0)
  );

  rns_mod_reduce #(.KIND(MK_POW2), .N(21), .W(R1_W), .PW(42)) u_red1 (
    .i_prod (r_p1),
    .i_acc  (r_acc.r1),
    .o_sum  (w_sum.r1)
  );

  rns_mod_reduce #(.KIND(MK_PLUS1), .N(22), .W(R2_W), .PW(46)) u_red2 (
    .i_prod (r_p2),
    .i_acc  (r_acc.r2),
    .o_sum  (w_sum.r2)
  );

  // Stage 2 accumulators and saturating term counter, cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (r_s1_valid)                  r_acc <= w_sum;
      if (w_accept && (r_cnt != '1))   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result register, loaded by the stage-2 beat that carries last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_terms <= '0;
    end else if (w_s2_done) begin
      r_out_data  <= w_sum;
      r_out_terms <= r_cnt;
    end
  end

endmodule

// File: tb/tb_rns_mac_64.sv
// tb/tb_rns_mac_64.sv - randomized self-checking bench for rns_mac_64
module tb_rns_mac_64;
  import rns64_pkg::*;

  localparam int CNT_W = 16;
  localparam longint unsigned MOD0 = 64'd2097151;
  localparam longint unsigned MOD1 = 64'd2097152;
  localparam longint unsigned MOD2 = 64'd4194305;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rns_mac_64_if #(.CNT_W(CNT_W)) bus ();

  rns_mac_64 #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  rns64_t qa[$];
  rns64_t qb[$];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rns64_t mk(input longint unsigned v2, input longint unsigned v1,
                                input longint unsigned v0);
    rns64_t r;
    r.r2 = 23'(v2);
    r.r1 = 21'(v1);
    r.r0 = 21'(v0);
    return r;
  endfunction

  function automatic rns64_t rand_rns();
    return mk($urandom_range(4194304), $urandom_range(2097151), $urandom_range(2097150));
  endfunction

  // Reference: plain modular sum of products over the queued burst.
  function automatic rns64_t model();
    longint unsigned s0 = 0, s1 = 0, s2 = 0;
    longint unsigned x, y;
    for (int i = 0; i < qa.size(); i++) begin
      x = qa[i].r0; y = qb[i].r0; s0 = (s0 + (x * y) % MOD0) % MOD0;
      x = qa[i].r1; y = qb[i].r1; s1 = (s1 + (x * y) % MOD1) % MOD1;
      x = qa[i].r2; y = qb[i].r2; s2 = (s2 + (x * y) % MOD2) % MOD2;
    end
    return mk(s2, s1, s0);
  endfunction

  function automatic logic [CNT_W-1:0] model_terms();
    return (qa.size() > 65535) ? '1 : CNT_W'(qa.size());
  endfunction

  task automatic push_eq(input int a, input int b);
    qa.push_back(mk(a, a, a));
    qb.push_back(mk(b, b, b));
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
    chk({tag, "_out_data"},  bus.out_data,  '0);
    chk({tag, "_out_terms"}, bus.out_terms, '0);
  endtask

  // Stream the queued burst, check latency, result, hold behaviour and release.
  task automatic play(input int bubble_pct, input int bubble_at, input int hold,
                      output rns64_t got);
    rns64_t           exp_d;
    logic [CNT_W-1:0] exp_t;
    int               waited;
    exp_d = model();
    exp_t = model_terms();
    for (int i = 0; i < qa.size(); i++) begin
      if (i == bubble_at || (bubble_pct > 0 && $urandom_range(99) < bubble_pct)) begin
        bus.in_valid = 1'b0;
        tick;
      end
      bus.in_valid = 1'b1;
      bus.in_a     = qa[i];
      bus.in_b     = qb[i];
      bus.in_last  = (i == qa.size() - 1);
      chk("in_ready_burst", bus.in_ready, 1'b1);
      tick;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("latency_early", bus.out_valid, 1'b0);
    chk("in_ready_drain", bus.in_ready, 1'b0);
    tick;
    chk("latency_out_valid", bus.out_valid, 1'b1);
    waited = 0;
    while (!bus.out_valid && waited < 8) begin
      tick;
      waited++;
    end
    got = bus.out_data;
    chk("out_data", bus.out_data, exp_d);
    chk("out_terms", bus.out_terms, exp_t);
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = rand_rns();
      bus.in_b      = rand_rns();
      bus.in_last   = 1'($urandom_range(1));
      tick;
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_out_data", bus.out_data, exp_d);
      chk("hold_out_terms", bus.out_terms, exp_t);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("release_out_valid", bus.out_valid, 1'b0);
    chk("release_in_ready", bus.in_ready, 1'b1);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    rns64_t got;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    chk_reset_state("reset");
    tick;
    chk("reset_in_ready_next", bus.in_ready, 1'b1);

    // Single term.
    push_eq(10, 10);
    play(0, -1, 0, got);
    chk("single_const", got, mk(100, 100, 100));

    // Three terms with a bubble between the second and third.
    push_eq(1, 2);
    push_eq(3, 4);
    push_eq(5, 6);
    play(0, 2, 0, got);
    chk("three_const", got, mk(44, 44, 44));

    // Modular wrap on every channel.
    qa.push_back(mk(4194304, 2097151, 2097150));
    qb.push_back(mk(4194304, 2097151, 2097150));
    play(0, -1, 0, got);
    chk("wrap_sq_const", got, mk(1, 1, 1));
    repeat (2) begin
      qa.push_back(mk(4194304, 0, 2097150));
      qb.push_back(mk(1, 0, 1));
    end
    play(0, -1, 0, got);
    chk("wrap_sum_const", got, mk(4194303, 0, 2097149));

    // Backpressure for 5 cycles with ignored input, then a fresh burst.
    push_eq(9, 9);
    play(0, -1, 5, got);
    push_eq(2, 3);
    play(0, -1, 0, got);
    chk("after_hold_const", got, mk(6, 6, 6));

    // Reset in the middle of a burst discards it.
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_a     = mk(11, 11, 11);
    bus.in_b     = mk(12, 12, 12);
    tick;
    tick;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_reset_state("midreset");
    push_eq(7, 7);
    play(0, -1, 0, got);
    chk("midreset_const", got, mk(49, 49, 49));

    // Randomized bursts with bubbles and backpressure.
    for (int k = 0; k < 25; k++) begin
      int n;
      n = $urandom_range(8, 1);
      for (int j = 0; j < n; j++) begin
        qa.push_back(rand_rns());
        qb.push_back(rand_rns());
      end
      play(30, -1, $urandom_range(3), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
